// File: rtl/apb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// apb_cmd_master_if
// Purpose : bundles the three signal groups around apb_cmd_master
//           - command from the instruction decoder (valid/ready + fields)
//           - APB master bus towards the peripheral slaves
//           - one-cycle response towards execute/writeback
// Modports:
//   master : view of apb_cmd_master (consumes cmd, drives APB + response)
//   slave  : view of the surrounding logic (decoder, slaves, writeback)
// ---------------------------------------------------------------------------
interface apb_cmd_master_if #(
    parameter int NUM_DEVICES = 4
);
    // decoder -> block
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [3:0]             opcode;
    logic [7:0]             apb_addr;
    logic [7:0]             apb_data;
    logic [3:0]             apb_device;

    // APB bus
    logic [NUM_DEVICES-1:0] psel;
    logic                   penable;
    logic                   pwrite;
    logic [7:0]             paddr;
    logic [7:0]             pwdata;
    logic [7:0]             prdata;
    logic                   pready;
    logic                   pslverr;

    // block -> writeback
    logic                   rsp_valid;
    logic [7:0]             rsp_rdata;
    logic                   rsp_err;

    modport master (
        input  cmd_valid, opcode, apb_addr, apb_data, apb_device,
        output cmd_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, opcode, apb_addr, apb_data, apb_device,
        input  cmd_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// Purpose : turns one decoded APB command (read or write) into a single APB
//           transfer (SETUP then ACCESS) and returns a one-cycle response with
//           read data and an error flag. Wait states are bounded by a timeout;
//           an out-of-range device index is answered with an error and never
//           touches the bus. Non-APB opcodes are consumed silently.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - apb_cmd_master_if.master: command (cmd_valid/cmd_ready, opcode,
//          apb_addr, apb_data, apb_device), APB (psel, penable, pwrite,
//          paddr, pwdata, prdata, pready, pslverr), response (rsp_valid,
//          rsp_rdata, rsp_err)
// ---------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int         NUM_DEVICES    = 4,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [3:0] OP_APB_WR      = 4'b1110,
    parameter logic [3:0] OP_APB_RD      = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    apb_cmd_master_if.master   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        BADDEV
    } state_t;

    state_t                 r_state;
    logic [NUM_DEVICES-1:0] r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [7:0]             r_paddr;
    logic [7:0]             r_pwdata;
    logic [CNT_W-1:0]       r_wait_cnt;
    logic                   r_rsp_valid;
    logic [7:0]             r_rsp_rdata;
    logic                   r_rsp_err;

    logic                   w_is_apb;
    logic                   w_dev_ok;
    logic [NUM_DEVICES-1:0] w_dev_onehot;

    assign w_is_apb = (bus.opcode == OP_APB_WR) || (bus.opcode == OP_APB_RD);
    assign w_dev_ok = {28'd0, bus.apb_device} < 32'(NUM_DEVICES);

    // Device decode. An out-of-range index yields all zeros, but that case is
    // routed to BADDEV and never reaches psel.
    for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_dev_dec
        assign w_dev_onehot[g] = ({28'd0, bus.apb_device} == 32'(g));
    end

    // Ready is a pure function of state, gated by reset so nothing is accepted
    // in the reset cycle.
    assign bus.cmd_ready = (r_state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Response strobe is a single-cycle pulse; only terminal
            // transitions below raise it.
            r_rsp_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid && w_is_apb) begin
                        if (w_dev_ok) begin
                            // psel is the latched device index in one-hot
                            // form; it is raised here so the SETUP cycle
                            // already shows it on the bus.
                            r_paddr  <= bus.apb_addr;
                            r_pwdata <= bus.apb_data;
                            r_pwrite <= (bus.opcode == OP_APB_WR);
                            r_psel   <= w_dev_onehot;
                            r_state  <= SETUP;
                        end else begin
                            r_state  <= BADDEV;
                        end
                    end
                    // Non-APB opcodes are consumed by cmd_ready and dropped.
                end

                SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ACCESS;
                end

                ACCESS: begin
                    if (bus.pready) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? 8'h00 : bus.prdata;
                        r_rsp_err   <= bus.pslverr;
                        r_state     <= IDLE;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        // Last allowed ACCESS cycle without pready: abort.
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 8'h00;
                        r_rsp_err   <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
                    end
                end

                BADDEV: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= 8'h00;
                    r_rsp_err   <= 1'b1;
                    r_state     <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
